// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg: shared definitions for the decode/hazard controller.
//   - opcode constants and instruction-field bit positions
//   - instruction-class enum and opcode-to-class helper
//   - pipeline control word {valid, we, rd}
//   - src_hit helper: does a source register collide with a stage writer
package decode_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_IALU   = 6'h08;
   localparam logic [5:0] OP_LOAD   = 6'h23;
   localparam logic [5:0] OP_STORE  = 6'h2B;
   localparam logic [5:0] OP_BRANCH = 6'h04;
   localparam logic [5:0] OP_NOP    = 6'h3F;

   localparam int unsigned OPC_HI = 31;
   localparam int unsigned OPC_LO = 26;
   localparam int unsigned RS1_HI = 25;
   localparam int unsigned RS1_LO = 21;
   localparam int unsigned RS2_HI = 20;
   localparam int unsigned RS2_LO = 16;
   localparam int unsigned RD_HI  = 15;
   localparam int unsigned RD_LO  = 11;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_IALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_NOP,
      CLS_UNKNOWN
   } instr_class_t;

   typedef struct packed {
      logic       valid;
      logic       we;
      logic [4:0] rd;
   } ctrl_word_t;

   function automatic instr_class_t opcode_class(input logic [5:0] opcode);
      instr_class_t cls;
      case (opcode)
         OP_RTYPE:  cls = CLS_RTYPE;
         OP_IALU:   cls = CLS_IALU;
         OP_LOAD:   cls = CLS_LOAD;
         OP_STORE:  cls = CLS_STORE;
         OP_BRANCH: cls = CLS_BRANCH;
         OP_NOP:    cls = CLS_NOP;
         default:   cls = CLS_UNKNOWN;
      endcase
      return cls;
   endfunction

   // r0 never hazards; writers to r0 already carry we=0.
   function automatic logic src_hit(input logic [4:0] src, input ctrl_word_t w);
      return (src != 5'd0) && w.valid && w.we && (w.rd == src);
   endfunction

endpackage

// File: rtl/decode_ctrl_if.sv
// decode_ctrl_if: fetch/decode-side bus of the decode controller.
//   master (fetch/bench): drives ir_valid, ir_in, flush
//   slave  (decode_ctrl): drives id_ready, the three operand latch enables,
//                         rf_we / rf_wr_addr (WB stage) and stall_cnt
// INSTR_W and CNT_W must match the parameters of the attached decode_ctrl.
interface decode_ctrl_if #(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned CNT_W   = 32
);
   logic               ir_valid;
   logic [INSTR_W-1:0] ir_in;
   logic               flush;
   logic               id_ready;
   logic               rega_latch_en;
   logic               regb_latch_en;
   logic               regimm_latch_en;
   logic               rf_we;
   logic [4:0]         rf_wr_addr;
   logic [CNT_W-1:0]   stall_cnt;

   modport master (
      output ir_valid, ir_in, flush,
      input  id_ready, rega_latch_en, regb_latch_en, regimm_latch_en,
             rf_we, rf_wr_addr, stall_cnt
   );

   modport slave (
      input  ir_valid, ir_in, flush,
      output id_ready, rega_latch_en, regb_latch_en, regimm_latch_en,
             rf_we, rf_wr_addr, stall_cnt
   );
endinterface

// File: rtl/decode_ctrl_classify.sv
// decode_ctrl_classify: purely combinational opcode decoder.
//   opcode    in  6  opcode field of the decode instruction
//   reads_rs1 out 1  instruction reads rs1
//   reads_rs2 out 1  instruction reads rs2
//   writes_rd out 1  instruction writes its destination
//   uses_imm  out 1  instruction needs the immediate register
module decode_ctrl_classify
   import decode_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output logic       reads_rs1,
   output logic       reads_rs2,
   output logic       writes_rd,
   output logic       uses_imm
);

   instr_class_t cls;

   always_comb begin
      cls       = opcode_class(opcode);
      reads_rs1 = 1'b0;
      reads_rs2 = 1'b0;
      writes_rd = 1'b0;
      uses_imm  = 1'b0;
      case (cls)
         CLS_RTYPE: begin
            reads_rs1 = 1'b1;
            reads_rs2 = 1'b1;
            writes_rd = 1'b1;
         end
         CLS_IALU, CLS_LOAD: begin
            reads_rs1 = 1'b1;
            writes_rd = 1'b1;
            uses_imm  = 1'b1;
         end
         CLS_STORE, CLS_BRANCH: begin
            reads_rs1 = 1'b1;
            reads_rs2 = 1'b1;
            uses_imm  = 1'b1;
         end
         // NOP and unknown opcodes behave identically: no operands at all.
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_ctrl.sv
// decode_ctrl: in-order decode stage controller with hazard stall, no forwarding.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset
//   bus  decode_ctrl_if.slave:
//        ir_valid/ir_in/flush in; id_ready, rega/regb/regimm_latch_en,
//        rf_we/rf_wr_addr (WB stage), stall_cnt (saturating) out
// Holds the EX/MEM/WB control-word registers and the stall counter.
module decode_ctrl
   import decode_ctrl_pkg::*;
#(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned CNT_W   = 32
) (
   input logic         clk,
   input logic         rst,
   decode_ctrl_if.slave bus
);

   logic [INSTR_W-1:0] ir;
   logic [5:0]         opcode;
   logic [4:0]         rs1;
   logic [4:0]         rs2;
   logic [4:0]         rd;
   logic               reads_rs1;
   logic               reads_rs2;
   logic               writes_rd;
   logic               uses_imm;
   logic               hazard;
   logic               issue;
   logic               stall;
   logic               unused_bits;

   ctrl_word_t         ex_q;
   ctrl_word_t         mem_q;
   ctrl_word_t         wb_q;
   ctrl_word_t         ex_next;
   logic [CNT_W-1:0]   stall_cnt_q;

   assign ir          = bus.ir_in;
   assign unused_bits = ^ir;
   assign opcode      = ir[OPC_HI:OPC_LO];
   assign rs1         = ir[RS1_HI:RS1_LO];
   assign rs2         = ir[RS2_HI:RS2_LO];
   assign rd          = (opcode == OP_RTYPE) ? ir[RD_HI:RD_LO] : ir[RS2_HI:RS2_LO];

   decode_ctrl_classify u_classify (
      .opcode    (opcode),
      .reads_rs1 (reads_rs1),
      .reads_rs2 (reads_rs2),
      .writes_rd (writes_rd),
      .uses_imm  (uses_imm)
   );

   // WB is included: the RF is not guaranteed write-first.
   always_comb begin
      hazard = (reads_rs1 && (src_hit(rs1, ex_q) || src_hit(rs1, mem_q) || src_hit(rs1, wb_q)))
            || (reads_rs2 && (src_hit(rs2, ex_q) || src_hit(rs2, mem_q) || src_hit(rs2, wb_q)));
      issue  = bus.ir_valid && !hazard && !bus.flush;
      stall  = bus.ir_valid && hazard && !bus.flush;

      ex_next = '0;
      if (issue) begin
         ex_next.valid = 1'b1;
         ex_next.we    = writes_rd && (rd != 5'd0);
         ex_next.rd    = ex_next.we ? rd : 5'd0;
      end
   end

   // flush squashes the word leaving EX; words already in MEM/WB proceed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q        <= '0;
         mem_q       <= '0;
         wb_q        <= '0;
         stall_cnt_q <= '0;
      end else begin
         ex_q  <= ex_next;
         mem_q <= bus.flush ? '0 : ex_q;
         wb_q  <= mem_q;
         if (stall && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.id_ready        = issue;
   assign bus.rega_latch_en   = issue && reads_rs1;
   assign bus.regb_latch_en   = issue && reads_rs2;
   assign bus.regimm_latch_en = issue && uses_imm;
   assign bus.rf_we           = wb_q.valid && wb_q.we;
   assign bus.rf_wr_addr      = wb_q.rd;
   assign bus.stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_decode_ctrl.sv
// tb_decode_ctrl: self-checking bench for decode_ctrl (CNT_W=4 to reach saturation).
module tb_decode_ctrl;
   import decode_ctrl_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   decode_ctrl_if #(.INSTR_W(32), .CNT_W(4)) bus ();

   decode_ctrl #(.INSTR_W(32), .CNT_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      bit          v;
      logic [31:0] ir;
      bit          fl;
      bit          rdy, a, b, imm, we;
      int          addr;
      int          cnt;
   } vec_t;

   vec_t tbl[33];

   function automatic logic [31:0] mk(input logic [5:0] op, input int f1, input int f2, input int f3);
      return {op, 5'(f1), 5'(f2), 5'(f3), 11'h0};
   endfunction

   function automatic vec_t V(input bit v, input logic [31:0] ir, input bit fl,
                              input bit rdy, input bit a, input bit b, input bit imm,
                              input bit we, input int addr, input int cnt);
      vec_t r;
      r.v = v; r.ir = ir; r.fl = fl; r.rdy = rdy; r.a = a; r.b = b; r.imm = imm;
      r.we = we; r.addr = addr; r.cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input bit r, input bit v, input logic [31:0] ins, input bit fl);
      @(negedge clk);
      rst          = r;
      bus.ir_valid = v;
      bus.ir_in    = ins;
      bus.flush    = fl;
      #1;
   endtask

   task automatic expect_all(input string tag, input bit rdy, input bit a, input bit b,
                             input bit imm, input bit we, input int addr, input int cnt);
      chk({tag, " id_ready"}, int'(bus.id_ready), int'(rdy));
      chk({tag, " rega_en"}, int'(bus.rega_latch_en), int'(a));
      chk({tag, " regb_en"}, int'(bus.regb_latch_en), int'(b));
      chk({tag, " regimm_en"}, int'(bus.regimm_latch_en), int'(imm));
      chk({tag, " rf_we"}, int'(bus.rf_we), int'(we));
      if (we) chk({tag, " rf_wr_addr"}, int'(bus.rf_wr_addr), addr);
      chk({tag, " stall_cnt"}, int'(bus.stall_cnt), cnt);
   endtask

   // Reference model: destinations issued 1, 2 and 3 cycles ago (0 = none).
   int hist[3];
   int mcnt;

   task automatic mdl_decode(input logic [31:0] ins, output bit r1, output bit r2,
                             output bit w, output bit imm, output int s1, output int s2,
                             output int d);
      int opc;
      opc = int'(ins >> 26) % 64;
      s1  = int'(ins >> 21) % 32;
      s2  = int'(ins >> 16) % 32;
      d   = (opc == 0) ? int'(ins >> 11) % 32 : s2;
      r1 = 0; r2 = 0; w = 0; imm = 0;
      if (opc == int'(OP_RTYPE)) begin
         r1 = 1; r2 = 1; w = 1;
      end else if (opc == int'(OP_IALU) || opc == int'(OP_LOAD)) begin
         r1 = 1; w = 1; imm = 1;
      end else if (opc == int'(OP_STORE) || opc == int'(OP_BRANCH)) begin
         r1 = 1; r2 = 1; imm = 1;
      end
   endtask

   function automatic bit in_flight(input int src);
      if (src == 0) return 0;
      foreach (hist[k]) if (hist[k] == src) return 1;
      return 0;
   endfunction

   logic [31:0] A1, A2, A3;
   logic [5:0]  ops[7];

   initial begin
      int prev;
      A1 = mk(OP_RTYPE, 1, 2, 3);
      A2 = mk(OP_RTYPE, 4, 5, 6);
      A3 = mk(OP_RTYPE, 3, 1, 4);

      bus.ir_valid = 1'b0;
      bus.ir_in    = '0;
      bus.flush    = 1'b0;

      // reset state, and combinational issue while in reset
      drive(1, 0, 32'h0, 0);
      expect_all("rst_idle", 0, 0, 0, 0, 0, 0, 0);
      chk("rst rf_wr_addr", int'(bus.rf_wr_addr), 0);
      drive(1, 1, A1, 0);
      expect_all("rst_valid", 1, 1, 1, 0, 0, 0, 0);
      drive(0, 0, 32'h0, 0);

      tbl[0]  = V(1, A1, 0, 1, 1, 1, 0, 0, 0, 0);
      tbl[1]  = V(1, A2, 0, 1, 1, 1, 0, 0, 0, 0);
      tbl[2]  = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[3]  = V(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
      tbl[4]  = V(0, 0, 0, 0, 0, 0, 0, 1, 6, 0);
      tbl[5]  = V(1, A1, 0, 1, 1, 1, 0, 0, 0, 0);
      tbl[6]  = V(1, A3, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[7]  = V(1, A3, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[8]  = V(1, A3, 0, 0, 0, 0, 0, 1, 3, 2);
      tbl[9]  = V(1, A3, 0, 1, 1, 1, 0, 0, 0, 3);
      tbl[10] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      tbl[11] = V(1, mk(OP_LOAD, 1, 0, 0), 0, 1, 1, 0, 1, 0, 0, 3);
      tbl[12] = V(1, mk(OP_STORE, 2, 0, 0), 0, 1, 1, 1, 1, 1, 4, 3);
      tbl[13] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      tbl[14] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      tbl[15] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      tbl[16] = V(1, mk(OP_LOAD, 1, 7, 0), 0, 1, 1, 0, 1, 0, 0, 3);
      tbl[17] = V(1, mk(OP_RTYPE, 7, 1, 8), 1, 0, 0, 0, 0, 0, 0, 3);
      tbl[18] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      tbl[19] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      tbl[20] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
      tbl[21] = V(1, mk(OP_NOP, 7, 7, 7), 0, 1, 0, 0, 0, 0, 0, 3);
      tbl[22] = V(1, mk(OP_IALU, 1, 9, 0), 0, 1, 1, 0, 1, 0, 0, 3);
      tbl[23] = V(1, mk(OP_BRANCH, 9, 2, 0), 0, 0, 0, 0, 0, 0, 0, 3);
      tbl[24] = V(1, mk(OP_BRANCH, 9, 2, 0), 0, 0, 0, 0, 0, 0, 0, 4);
      tbl[25] = V(1, mk(OP_BRANCH, 9, 2, 0), 0, 0, 0, 0, 0, 1, 9, 5);
      tbl[26] = V(1, mk(OP_BRANCH, 9, 2, 0), 0, 1, 1, 1, 1, 0, 0, 6);
      tbl[27] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
      tbl[28] = V(1, mk(6'h15, 9, 9, 9), 0, 1, 0, 0, 0, 0, 0, 6);
      tbl[29] = V(1, A1, 1, 0, 0, 0, 0, 0, 0, 6);
      tbl[30] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
      tbl[31] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
      tbl[32] = V(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);

      for (int i = 0; i < 33; i++) begin
         drive(0, tbl[i].v, tbl[i].ir, tbl[i].fl);
         expect_all($sformatf("tbl%0d", i), tbl[i].rdy, tbl[i].a, tbl[i].b,
                    tbl[i].imm, tbl[i].we, tbl[i].addr, tbl[i].cnt);
      end

      // reset one cycle after issuing ADD r3: nothing retires afterwards
      drive(0, 1, A1, 0);
      chk("midrst issue", int'(bus.id_ready), 1);
      drive(1, 0, 32'h0, 0);
      chk("midrst cnt_clear", int'(bus.stall_cnt), 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 32'h0, 0);
         chk($sformatf("midrst rf_we c%0d", i), int'(bus.rf_we), 0);
         chk($sformatf("midrst cnt c%0d", i), int'(bus.stall_cnt), 0);
      end

      // first cycle after reset release issues normally
      drive(1, 0, 32'h0, 0);
      drive(0, 1, A2, 0);
      chk("post_rst issue", int'(bus.id_ready), 1);
      drive(0, 0, 32'h0, 0);
      drive(0, 0, 32'h0, 0);
      drive(0, 0, 32'h0, 0);
      chk("post_rst rf_we", int'(bus.rf_we), 1);
      chk("post_rst addr", int'(bus.rf_wr_addr), 6);

      // self-dependent chain: stall 3, issue 1, repeat -> saturate at 15
      drive(1, 0, 32'h0, 0);
      drive(0, 1, A1, 0);
      prev = 0;
      for (int i = 0; i < 40; i++) begin
         drive(0, 1, mk(OP_RTYPE, 3, 1, 3), 0);
         if (i == 8) chk("sat partial", int'(bus.stall_cnt), 6);
         chk($sformatf("sat nowrap c%0d", i), int'(int'(bus.stall_cnt) >= prev), 1);
         prev = int'(bus.stall_cnt);
      end
      chk("sat final", int'(bus.stall_cnt), 15);

      // randomized traffic against the reference model
      ops = '{OP_RTYPE, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_NOP, 6'h15};
      drive(1, 0, 32'h0, 0);
      foreach (hist[k]) hist[k] = 0;
      mcnt = 0;
      for (int i = 0; i < 500; i++) begin
         bit          r, v, fl, r1, r2, w, imm, haz, iss;
         int          s1, s2, d;
         logic [31:0] ins;
         r   = ($urandom_range(49) == 0);
         v   = ($urandom_range(9) < 8);
         fl  = ($urandom_range(9) == 0);
         ins = {ops[$urandom_range(6)], 5'($urandom_range(3)), 5'($urandom_range(3)),
                5'($urandom_range(3)), 11'($urandom)};
         drive(r, v, ins, fl);
         if (r) begin
            foreach (hist[k]) hist[k] = 0;
            mcnt = 0;
         end
         mdl_decode(ins, r1, r2, w, imm, s1, s2, d);
         haz = (r1 && in_flight(s1)) || (r2 && in_flight(s2));
         iss = v && !haz && !fl;
         expect_all($sformatf("rnd%0d", i), iss, iss && r1, iss && r2, iss && imm,
                    hist[2] != 0, hist[2], mcnt);
         if (!r) begin
            if (v && haz && !fl && mcnt < 15) mcnt++;
            hist[2] = hist[1];
            hist[1] = fl ? 0 : hist[0];
            hist[0] = (iss && w && d != 0) ? d : 0;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
